row_mac_sequencer: RTL and testbench

- Row-level sequencer for the shared multiply-accumulate datapath of the matrix-multiply engine.
- Started by the main controller's begin_mult / row index; walks every result column j and inner index k of one result row.
- Drives operand-memory reads, MAC clear/enable and result-buffer writes; pulses done_row when the row is finished.

---
 rtl/row_mac_sequencer_if.sv | 63 ++++++
 rtl/row_mac_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_row_mac_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// row_mac_sequencer_if
//   Bundles the sequencer's controller request, operand-memory read, MAC
//   control, result-buffer write and status signals.
//
//   Signals:
//     begin_mult   level request to process a row          (controller -> seq)
//     row_idx      result row to compute, sampled on start  (controller -> seq)
//     mem_rd_en    operand read strobe for A and B
//     a_addr       A address  = row*N + k
//     b_addr       B address  = k*N + j
//     mac_clear    zero the accumulator at the next edge
//     mac_en       accumulate the product of the current read data
//     res_wr_en    write accumulator to the result buffer
//     res_wr_addr  result address = row*N + j
//     done_row     one-cycle pulse, row complete
//     row_err      one-cycle pulse with done_row when row_idx >= N
//     busy         high whenever the sequencer is not idle
//     row_cycles   total cycles of the last row (only with ROW_MAC_CYCLE_CNT_EN)
//
//   Modports: master = main controller side, slave = sequencer side.
//   Optional macro: ROW_MAC_CYCLE_CNT_EN adds row_cycles.
// -----------------------------------------------------------------------------
interface row_mac_sequencer_if #(
    parameter int ROW_W  = 4,
    parameter int ADDR_W = 8
) ();

    logic              begin_mult;
    logic [ROW_W-1:0]  row_idx;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              mac_clear;
    logic              mac_en;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic              done_row;
    logic              row_err;
    logic              busy;
`ifdef ROW_MAC_CYCLE_CNT_EN
    logic [15:0]       row_cycles;
`endif

    modport master (
        output begin_mult, row_idx,
        input  mem_rd_en, a_addr, b_addr, mac_clear, mac_en,
        input  res_wr_en, res_wr_addr, done_row, row_err, busy
`ifdef ROW_MAC_CYCLE_CNT_EN
        , input row_cycles
`endif
    );

    modport slave (
        input  begin_mult, row_idx,
        output mem_rd_en, a_addr, b_addr, mac_clear, mac_en,
        output res_wr_en, res_wr_addr, done_row, row_err, busy
`ifdef ROW_MAC_CYCLE_CNT_EN
        , output row_cycles
`endif
    );

endinterface

// File: rtl/row_mac_sequencer.sv
// -----------------------------------------------------------------------------
// row_mac_sequencer
//   Row-level sequencer for the shared multiply-accumulate datapath. On a
//   begin_mult request in IDLE it latches the row, then for every result
//   column j: clears the MAC, issues N operand reads (k = 0..N-1), waits for
//   the read latency to drain, and writes the accumulator to the result
//   buffer. done_row pulses once the whole row has been written.
//
//   Ports:
//     clk      rising-edge clock
//     n_reset  asynchronous active-low reset
//     bus      row_mac_sequencer_if.slave (request in, memory/MAC/result out)
//
//   Parameters: N (matrix dimension), ROW_W (row_idx width),
//               ADDR_W (flat address width), RD_LAT (read latency, >= 1).
//   Optional macro: ROW_MAC_CYCLE_CNT_EN adds bus.row_cycles, the total
//   cycle count of the last row (saturating 16-bit), valid in the DONE cycle.
// -----------------------------------------------------------------------------
module row_mac_sequencer #(
    parameter int N      = 10,
    parameter int ROW_W  = 4,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   n_reset,
    row_mac_sequencer_if.slave     bus
);

    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(RD_LAT + 1);

    localparam logic [CW-1:0]     LAST_IDX   = CW'(N - 1);
    localparam logic [DW-1:0]     LAST_DRAIN = DW'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] N_A        = ADDR_W'(N);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t            state_q,    state_d;
    logic [CW-1:0]     j_q,        j_d;
    logic [CW-1:0]     k_q,        k_d;
    logic [DW-1:0]     drain_q,    drain_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] a_addr_q,   a_addr_d;
    logic [ADDR_W-1:0] b_addr_q,   b_addr_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic              err_q,      err_d;
    logic [RD_LAT-1:0] rd_pipe_q,  rd_pipe_d;
    logic              rd_issue;

`ifdef ROW_MAC_CYCLE_CNT_EN
    logic [15:0]       cyc_cnt_q,    cyc_cnt_d;
    logic [15:0]       row_cycles_q, row_cycles_d;
    logic [15:0]       cyc_next;
`endif

    assign rd_issue = (state_q == ISSUE);

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        k_d        = k_q;
        drain_d    = drain_q;
        row_base_d = row_base_q;
        a_addr_d   = a_addr_q;
        b_addr_d   = b_addr_q;
        res_addr_d = res_addr_q;
        err_d      = err_q;
        // Shift the read strobe towards mac_en; the oldest stage falls off.
        rd_pipe_d  = RD_LAT'({rd_pipe_q, rd_issue});

        case (state_q)
            IDLE: begin
                if (bus.begin_mult) begin
                    j_d = '0;
                    k_d = '0;
                    if (32'(bus.row_idx) < 32'(N)) begin
                        // Row base is registered here so no multiplier feeds
                        // the address outputs.
                        row_base_d = ADDR_W'(bus.row_idx) * N_A;
                        err_d      = 1'b0;
                        state_d    = CLEAR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            CLEAR: begin
                k_d        = '0;
                a_addr_d   = row_base_q;
                b_addr_d   = ADDR_W'(j_q);
                res_addr_d = row_base_q + ADDR_W'(j_q);
                state_d    = ISSUE;
            end

            ISSUE: begin
                if (k_q == LAST_IDX) begin
                    // Addresses hold on the last read so they never step
                    // past N*N-1.
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    k_d      = k_q + CW'(1);
                    a_addr_d = a_addr_q + ADDR_W'(1);
                    b_addr_d = b_addr_q + N_A;
                end
            end

            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = WRITE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end

            WRITE: begin
                if (j_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + CW'(1);
                    state_d = CLEAR;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ROW_MAC_CYCLE_CNT_EN
        // Cycle 1 of a row is the cycle after the start edge.
        cyc_next     = (state_q == IDLE) ? 16'd1 :
                       ((cyc_cnt_q == 16'hFFFF) ? cyc_cnt_q : cyc_cnt_q + 16'd1);
        cyc_cnt_d    = cyc_cnt_q;
        row_cycles_d = row_cycles_q;
        if (state_d != IDLE) begin
            cyc_cnt_d = cyc_next;
        end
        if ((state_d == DONE) && (state_q != DONE)) begin
            row_cycles_d = cyc_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            j_q        <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            row_base_q <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            res_addr_q <= '0;
            err_q      <= 1'b0;
            rd_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            row_base_q <= row_base_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
            res_addr_q <= res_addr_d;
            err_q      <= err_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

`ifdef ROW_MAC_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cyc_cnt_q    <= '0;
            row_cycles_q <= '0;
        end else begin
            cyc_cnt_q    <= cyc_cnt_d;
            row_cycles_q <= row_cycles_d;
        end
    end

    assign bus.row_cycles = row_cycles_q;
`endif

    assign bus.mem_rd_en   = rd_issue;
    assign bus.a_addr      = a_addr_q;
    assign bus.b_addr      = b_addr_q;
    assign bus.mac_clear   = (state_q == CLEAR);
    assign bus.mac_en      = rd_pipe_q[RD_LAT-1];
    assign bus.res_wr_en   = (state_q == WRITE);
    assign bus.res_wr_addr = res_addr_q;
    assign bus.done_row    = (state_q == DONE);
    assign bus.row_err     = (state_q == DONE) && err_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_row_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_row_mac_sequencer
//   Scoreboard bench: every started row pushes its expected clear/read/mac/
//   write/done events, stamped with the cycle they must appear in; a negedge
//   monitor pops and compares them against the DUT. A second instance with
//   RD_LAT=3 checks read-latency timing against the observed read strobe.
// -----------------------------------------------------------------------------
module tb_row_mac_sequencer;

    localparam int N       = 10;
    localparam int ROW_W   = 4;
    localparam int ADDR_W  = 8;
    localparam int RD_LAT  = 1;
    localparam int RD_LAT3 = 3;
    localparam int L1      = N + RD_LAT + 2;
    localparam int L3      = N + RD_LAT3 + 2;

    localparam int K_CLR  = 0;
    localparam int K_RD   = 1;
    localparam int K_MAC  = 2;
    localparam int K_WR   = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int          kind;
        int unsigned cyc;
        int unsigned a;
        int unsigned b;
    } ev_t;

    logic        clk = 1'b0;
    logic        n_reset;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    ev_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    row_mac_sequencer_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus  ();
    row_mac_sequencer_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus3 ();

    row_mac_sequencer #(.N(N), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.slave)
    );

    row_mac_sequencer #(.N(N), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT3)) u_dut3 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus3.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rd_en"},  32'(bus.mem_rd_en), 0);
        check_val({tag, "_a"},      32'(bus.a_addr), 0);
        check_val({tag, "_b"},      32'(bus.b_addr), 0);
        check_val({tag, "_clr"},    32'(bus.mac_clear), 0);
        check_val({tag, "_mac"},    32'(bus.mac_en), 0);
        check_val({tag, "_wr_en"},  32'(bus.res_wr_en), 0);
        check_val({tag, "_wr_a"},   32'(bus.res_wr_addr), 0);
        check_val({tag, "_done"},   32'(bus.done_row), 0);
        check_val({tag, "_err"},    32'(bus.row_err), 0);
        check_val({tag, "_busy"},   32'(bus.busy), 0);
        check_val({tag, "_busy3"},  32'(bus3.busy), 0);
        check_val({tag, "_mac3"},   32'(bus3.mac_en), 0);
`ifdef ROW_MAC_CYCLE_CNT_EN
        check_val({tag, "_rcyc"},   32'(bus.row_cycles), 0);
`endif
    endtask

    // c0 is the tb cycle count when the request is driven; the start edge is
    // the next posedge, so relative cycle m is observed at cyc == c0 + m.
    task automatic push_row(input int unsigned r, input int unsigned c0, output int unsigned done_c);
        if (r >= N) begin
            done_c = c0 + 1;
            sb_q.push_back('{K_DONE, done_c, 1, 1});
            return;
        end
        for (int unsigned col = 0; col < N; col++) begin
            int unsigned t0;
            t0 = c0 + col * L1;
            sb_q.push_back('{K_CLR, t0 + 1, 0, 0});
            for (int unsigned k = 0; k < N; k++) begin
                sb_q.push_back('{K_RD, t0 + 2 + k, r * N + k, k * N + col});
                sb_q.push_back('{K_MAC, t0 + 2 + k + RD_LAT, 0, 0});
            end
            sb_q.push_back('{K_WR, t0 + L1, r * N + col, 0});
        end
        done_c = c0 + 1 + N * L1;
        sb_q.push_back('{K_DONE, done_c, 0, done_c - c0});
    endtask

    task automatic wait_until(input int unsigned target);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < target);
    endtask

    // ---------------- main-DUT monitor ----------------
    bit          e_clr, e_rd, e_mac, e_wr, e_done;
    ev_t         rd_e, wr_e, done_e;
    int          wr_count = 0;
    int          done_count = 0;
    int unsigned last_wr_addr = 0;

    always @(negedge clk) begin
        e_clr = 0; e_rd = 0; e_mac = 0; e_wr = 0; e_done = 0;
        for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                case (sb_q[i].kind)
                    K_CLR:  e_clr = 1;
                    K_RD:   begin e_rd = 1;   rd_e = sb_q[i];   end
                    K_MAC:  e_mac = 1;
                    K_WR:   begin e_wr = 1;   wr_e = sb_q[i];   end
                    K_DONE: begin e_done = 1; done_e = sb_q[i]; end
                    default: ;
                endcase
                sb_q.delete(i);
            end
        end
        if (bus.mac_clear || e_clr)
            check_val("mac_clear", 32'(bus.mac_clear), 32'(e_clr));
        if (bus.mem_rd_en || e_rd) begin
            check_val("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd));
            if (bus.mem_rd_en && e_rd) begin
                check_val("a_addr", 32'(bus.a_addr), rd_e.a);
                check_val("b_addr", 32'(bus.b_addr), rd_e.b);
            end
        end
        if (bus.mac_en || e_mac)
            check_val("mac_en", 32'(bus.mac_en), 32'(e_mac));
        if (bus.res_wr_en || e_wr) begin
            check_val("res_wr_en", 32'(bus.res_wr_en), 32'(e_wr));
            if (bus.res_wr_en && e_wr)
                check_val("res_wr_addr", 32'(bus.res_wr_addr), wr_e.a);
        end
        if (bus.done_row || bus.row_err || e_done) begin
            check_val("done_row", 32'(bus.done_row), 32'(e_done));
            check_val("row_err", 32'(bus.row_err), e_done ? done_e.a : 0);
`ifdef ROW_MAC_CYCLE_CNT_EN
            if (e_done)
                check_val("row_cycles", 32'(bus.row_cycles), done_e.b);
`endif
        end
        if (bus.res_wr_en) begin
            wr_count++;
            last_wr_addr = 32'(bus.res_wr_addr);
        end
        if (bus.done_row)
            done_count++;
    end

    // ---------------- RD_LAT=3 monitor ----------------
    logic [2:0]  rd_hist3 = '0;
    int          rd3_count = 0, mac3_count = 0, wr3_count = 0, done3_count = 0;
    int unsigned last_rd3 = 0, done3_cyc = 0;

    always @(negedge clk) begin
        if (bus3.mac_en || rd_hist3[2])
            check_val("mac_en_lag3", 32'(bus3.mac_en), 32'(rd_hist3[2]));
        if (bus3.res_wr_en) begin
            wr3_count++;
            check_val("wr3_gap", cyc - last_rd3, 4);
        end
        if (bus3.done_row) begin
            done3_count++;
            done3_cyc = cyc;
            check_val("row_err3", 32'(bus3.row_err), 0);
`ifdef ROW_MAC_CYCLE_CNT_EN
            check_val("row_cycles3", 32'(bus3.row_cycles), 1 + N * L3);
`endif
        end
        if (bus3.mem_rd_en) begin
            rd3_count++;
            last_rd3 = cyc;
        end
        if (bus3.mac_en)
            mac3_count++;
        rd_hist3 = {rd_hist3[1:0], bus3.mem_rd_en};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0, done_c, c3;

        n_reset          = 1'b1;
        bus.begin_mult   = 1'b1;
        bus.row_idx      = '0;
        bus3.begin_mult  = 1'b0;
        bus3.row_idx     = '0;
        #2 n_reset = 1'b0;
        #1 check_idle_outputs("rst");
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("rst_clk");

        // Rows 0..9 back to back with begin_mult held high.
        n_reset = 1'b1;
        for (int unsigned r = 0; r < N; r++) begin
            c0 = cyc;
            bus.row_idx = ROW_W'(r);
            push_row(r, c0, done_c);
            wait_until(done_c + 1);
        end
        bus.begin_mult = 1'b0;
        check_val("rows_done_cnt", 32'(done_count), N);
        check_val("rows_wr_cnt", 32'(wr_count), N * N);
        check_val("last_wr_addr", last_wr_addr, N * N - 1);
        check_val("idle_busy", 32'(bus.busy), 0);
        wait_until(cyc + 3);

        // begin_mult dropped and row_idx changed mid-row: row 5 completes.
        c0 = cyc;
        bus.begin_mult = 1'b1;
        bus.row_idx    = 4'd5;
        push_row(5, c0, done_c);
        wait_until(c0 + 3);
        bus.begin_mult = 1'b0;
        bus.row_idx    = 4'd7;
        wait_until(done_c + 2);

        // Out-of-range row: immediate done with row_err.
        c0 = cyc;
        bus.begin_mult = 1'b1;
        bus.row_idx    = 4'd12;
        push_row(12, c0, done_c);
        wait_until(c0 + 1);
        bus.begin_mult = 1'b0;
        wait_until(done_c + 3);

        // Reset in cycle 50 of row 3, then restart row 3 from scratch.
        c0 = cyc;
        bus.begin_mult = 1'b1;
        bus.row_idx    = 4'd3;
        push_row(3, c0, done_c);
        wait_until(c0 + 49);
        check_val("mid_busy", 32'(bus.busy), 1);
        wait_until(c0 + 50);
        n_reset = 1'b0;
        sb_q.delete();
        #1 check_idle_outputs("mid_rst");
        wait_until(cyc + 2);
        n_reset = 1'b1;
        c0 = cyc;
        push_row(3, c0, done_c);
        wait_until(done_c + 1);
        bus.begin_mult = 1'b0;
        wait_until(cyc + 3);

        // RD_LAT=3 instance, row 0.
        c3 = cyc;
        bus3.begin_mult = 1'b1;
        bus3.row_idx    = '0;
        wait_until(c3 + 2);
        bus3.begin_mult = 1'b0;
        wait_until(c3 + 1 + N * L3 + 4);
        check_val("done3_cnt", 32'(done3_count), 1);
        check_val("done3_cycle", done3_cyc, c3 + 1 + N * L3);
        check_val("rd3_cnt", 32'(rd3_count), N * N);
        check_val("mac3_cnt", 32'(mac3_count), N * N);
        check_val("wr3_cnt", 32'(wr3_count), N);

        check_val("sb_left", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
